// File: rtl/gate_scheduler_if.sv
// gate_scheduler_if
// Groups the handshake and status signals between the gate scheduler and
// its surroundings (sequence controller, gate units, element-wise unit).
//   master : drives startSeq/numSteps/abort/gateReady/elemDone and
//            observes the scheduler strobes and status.
//   slave  : the scheduler itself.
interface gate_scheduler_if #(
    parameter int NUM_GATES = 4,
    parameter int MAX_STEPS = 16
);
    localparam int STEP_BW = $clog2(MAX_STEPS) + 1;

    logic                 startSeq;
    logic [STEP_BW-1:0]   numSteps;
    logic                 abort;
    logic [NUM_GATES-1:0] gateReady;
    logic                 elemDone;
    logic                 inputRead;
    logic                 beginCalc;
    logic                 beginElem;
    logic                 hiddenWrite;
    logic [STEP_BW-1:0]   stepIndex;
    logic                 busy;
    logic                 seqDone;

    modport master (
        output startSeq, numSteps, abort, gateReady, elemDone,
        input  inputRead, beginCalc, beginElem, hiddenWrite, stepIndex, busy, seqDone
    );

    modport slave (
        input  startSeq, numSteps, abort, gateReady, elemDone,
        output inputRead, beginCalc, beginElem, hiddenWrite, stepIndex, busy, seqDone
    );
endinterface

// File: rtl/gate_scheduler.sv
// gate_scheduler
// Sequences one recurrent-cell timestep at a time: load input, start all
// gate units, collect their ready pulses, run the element-wise unit, then
// commit the new hidden state. Repeats for the latched number of steps.
// Ports:
//   clock  : single rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : gate_scheduler_if.slave (start/abort/ready inputs, strobes,
//            stepIndex, busy, seqDone outputs)
// All strobes and busy are flops loaded from the next-state decode, so they
// line up exactly with the state they belong to and clear on reset at once.
module gate_scheduler #(
    parameter int NUM_GATES = 4,
    parameter int MAX_STEPS = 16
) (
    input logic             clock,
    input logic             reset,
    gate_scheduler_if.slave bus
);
    localparam int STEP_BW = $clog2(MAX_STEPS) + 1;
    localparam logic [STEP_BW-1:0]   STEP_ZERO = {STEP_BW{1'b0}};
    localparam logic [STEP_BW-1:0]   STEP_ONE  = STEP_BW'(1);
    localparam logic [STEP_BW-1:0]   STEP_MAX  = STEP_BW'(MAX_STEPS);
    localparam logic [NUM_GATES-1:0] MASK_ZERO = {NUM_GATES{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_START_GATES = 3'd2,
        S_WAIT_GATES  = 3'd3,
        S_START_ELEM  = 3'd4,
        S_WAIT_ELEM   = 3'd5,
        S_UPDATE      = 3'd6,
        S_DONE        = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [STEP_BW-1:0]   step_q, step_d;
    logic [STEP_BW-1:0]   count_q, count_d;
    logic [NUM_GATES-1:0] mask_q, mask_d;
    logic [NUM_GATES-1:0] mask_merged_s;
    logic                 input_read_q, input_read_d;
    logic                 begin_calc_q, begin_calc_d;
    logic                 begin_elem_q, begin_elem_d;
    logic                 hidden_write_q, hidden_write_d;
    logic                 seq_done_q, seq_done_d;
    logic                 busy_q, busy_d;

    // Next-state, counter and ready-mask computation.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        count_d       = count_q;
        mask_d        = mask_q;
        // Pulses in the current cycle count toward completion immediately.
        mask_merged_s = mask_q | bus.gateReady;

        if ((state_q != S_IDLE) && bus.abort) begin
            // Abort beats every other transition and skips UPDATE/DONE.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.startSeq) begin
                        count_d = (bus.numSteps > STEP_MAX) ? STEP_MAX : bus.numSteps;
                        step_d  = STEP_ZERO;
                        state_d = (bus.numSteps == STEP_ZERO) ? S_DONE : S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD:        state_d = S_START_GATES;
                S_START_GATES: begin
                    mask_d  = MASK_ZERO;
                    state_d = S_WAIT_GATES;
                end
                S_WAIT_GATES: begin
                    mask_d = mask_merged_s;
                    if (&mask_merged_s) begin
                        state_d = S_START_ELEM;
                    end else begin
                        state_d = S_WAIT_GATES;
                    end
                end
                S_START_ELEM:  state_d = S_WAIT_ELEM;
                S_WAIT_ELEM: begin
                    if (bus.elemDone) begin
                        state_d = S_UPDATE;
                    end else begin
                        state_d = S_WAIT_ELEM;
                    end
                end
                S_UPDATE: begin
                    // stepIndex stays on the last step when the sequence ends.
                    if ((step_q + STEP_ONE) == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + STEP_ONE;
                        state_d = S_LOAD;
                    end
                end
                S_DONE:        state_d = S_IDLE;
                default:       state_d = S_IDLE;
            endcase
        end

        input_read_d   = (state_d == S_LOAD);
        begin_calc_d   = (state_d == S_START_GATES);
        begin_elem_d   = (state_d == S_START_ELEM);
        hidden_write_d = (state_d == S_UPDATE);
        seq_done_d     = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
    end

    // State, counters, mask and registered output strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            step_q         <= STEP_ZERO;
            count_q        <= STEP_ZERO;
            mask_q         <= MASK_ZERO;
            input_read_q   <= 1'b0;
            begin_calc_q   <= 1'b0;
            begin_elem_q   <= 1'b0;
            hidden_write_q <= 1'b0;
            seq_done_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            count_q        <= count_d;
            mask_q         <= mask_d;
            input_read_q   <= input_read_d;
            begin_calc_q   <= begin_calc_d;
            begin_elem_q   <= begin_elem_d;
            hidden_write_q <= hidden_write_d;
            seq_done_q     <= seq_done_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.inputRead   = input_read_q;
    assign bus.beginCalc   = begin_calc_q;
    assign bus.beginElem   = begin_elem_q;
    assign bus.hiddenWrite = hidden_write_q;
    assign bus.seqDone     = seq_done_q;
    assign bus.busy        = busy_q;
    assign bus.stepIndex   = step_q;
endmodule

// File: tb/tb_gate_scheduler.sv
// Testbench for gate_scheduler: table of whole-sequence vectors driven
// through an automatic gate/element responder, with a scoreboard of expected
// stepIndex values per inputRead/hiddenWrite, plus hand-written sequences
// for ready-mask accumulation, abort and asynchronous reset.
module tb_gate_scheduler;
    localparam int NUM_GATES = 4;
    localparam int MAX_STEPS = 16;
    localparam int STEP_BW   = $clog2(MAX_STEPS) + 1;

    typedef struct {
        int num_steps;
        int gate_dly;
        int elem_dly;
        int exp_steps;
        int exp_cycles;
        bit hold_start;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    gate_scheduler_if #(.NUM_GATES(NUM_GATES), .MAX_STEPS(MAX_STEPS)) bus ();

    gate_scheduler #(.NUM_GATES(NUM_GATES), .MAX_STEPS(MAX_STEPS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit auto_resp = 1'b0;
    int gate_dly = 1;
    int elem_dly = 1;
    int gate_cnt = 0;
    int elem_cnt = 0;
    int exp_ir_q[$];
    int exp_hw_q[$];
    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        chk_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and run the gate/element responder.
    task automatic tick();
        @(negedge clock);
        if (auto_resp) begin
            bus.gateReady = {NUM_GATES{1'b0}};
            bus.elemDone  = 1'b0;
            if (gate_cnt > 0) begin
                gate_cnt--;
                if (gate_cnt == 0) bus.gateReady = {NUM_GATES{1'b1}};
            end
            if (elem_cnt > 0) begin
                elem_cnt--;
                if (elem_cnt == 0) bus.elemDone = 1'b1;
            end
            if (bus.beginCalc) gate_cnt = gate_dly;
            if (bus.beginElem) elem_cnt = elem_dly;
        end
    endtask

    // Scoreboard: compare stepIndex against the queued expectation.
    task automatic observe();
        if (bus.inputRead) begin
            check("inputRead_expected", int'(exp_ir_q.size() > 0), 1);
            if (exp_ir_q.size() > 0)
                check("inputRead_stepIndex", int'(bus.stepIndex), exp_ir_q.pop_front());
        end
        if (bus.hiddenWrite) begin
            check("hiddenWrite_expected", int'(exp_hw_q.size() > 0), 1);
            if (exp_hw_q.size() > 0)
                check("hiddenWrite_stepIndex", int'(bus.stepIndex), exp_hw_q.pop_front());
        end
    endtask

    task automatic run_seq(input vec_t v);
        int ir_cnt = 0;
        int bc_cnt = 0;
        int be_cnt = 0;
        int hw_cnt = 0;
        int done_at = -1;
        int busy_gap = 0;
        int last_ir = -1;
        int spacing_bad = 0;
        int step_len = 4 + v.gate_dly + v.elem_dly;
        auto_resp = 1'b1;
        gate_dly  = v.gate_dly;
        elem_dly  = v.elem_dly;
        gate_cnt  = 0;
        elem_cnt  = 0;
        exp_ir_q.delete();
        exp_hw_q.delete();
        for (int i = 0; i < v.exp_steps; i++) begin
            exp_ir_q.push_back(i);
            exp_hw_q.push_back(i);
        end
        bus.startSeq = 1'b1;
        bus.numSteps = STEP_BW'(v.num_steps);
        for (int k = 1; (k <= v.exp_cycles + 40) && (done_at < 0); k++) begin
            tick();
            if (v.hold_start) bus.numSteps = STEP_BW'(2);
            else bus.startSeq = 1'b0;
            observe();
            if (bus.inputRead) begin
                ir_cnt++;
                if ((last_ir >= 0) && (k - last_ir != step_len)) spacing_bad++;
                last_ir = k;
            end
            if (bus.beginCalc)   bc_cnt++;
            if (bus.beginElem)   be_cnt++;
            if (bus.hiddenWrite) hw_cnt++;
            if (!bus.busy)       busy_gap++;
            if (bus.seqDone) begin
                done_at = k;
                bus.startSeq = 1'b0;
            end
        end
        check("seqDone_cycle", done_at, v.exp_cycles);
        check("inputRead_count", ir_cnt, v.exp_steps);
        check("beginCalc_count", bc_cnt, v.exp_steps);
        check("beginElem_count", be_cnt, v.exp_steps);
        check("hiddenWrite_count", hw_cnt, v.exp_steps);
        check("step_spacing_errors", spacing_bad, 0);
        check("busy_low_while_running", busy_gap, 0);
        check("scoreboard_left", exp_hw_q.size() + exp_ir_q.size(), 0);
        tick();
        check("busy_after_done", int'(bus.busy), 0);
        check("seqDone_width", int'(bus.seqDone), 0);
    endtask

    initial begin
        int found;
        int extra;
        vecs[0] = '{3, 5, 2, 3, 34, 1'b0};
        vecs[1] = '{0, 1, 1, 0, 1, 1'b0};
        vecs[2] = '{1, 1, 1, 1, 7, 1'b0};
        vecs[3] = '{MAX_STEPS + 5, 1, 1, MAX_STEPS, 97, 1'b1};
        vecs[4] = '{5, 1, 3, 5, 41, 1'b0};
        vecs[5] = '{MAX_STEPS, 2, 1, MAX_STEPS, 113, 1'b0};
        vecs[6] = '{2, 3, 4, 2, 23, 1'b0};

        reset         = 1'b1;
        bus.startSeq  = 1'b0;
        bus.numSteps  = {STEP_BW{1'b0}};
        bus.abort     = 1'b0;
        bus.gateReady = {NUM_GATES{1'b0}};
        bus.elemDone  = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_stepIndex", int'(bus.stepIndex), 0);
        check("reset_strobes", int'({bus.inputRead, bus.beginCalc, bus.beginElem,
                                     bus.hiddenWrite, bus.seqDone}), 0);
        reset = 1'b0;
        tick();
        check("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 7; i++) run_seq(vecs[i]);

        // Ready mask accumulation across cycles; pulses outside WAIT_GATES ignored.
        auto_resp = 1'b0;
        found = 0;
        bus.startSeq = 1'b1;
        bus.numSteps = STEP_BW'(1);
        for (int k = 0; (k < 10) && (found == 0); k++) begin
            tick();
            bus.startSeq = 1'b0;
            if (bus.beginCalc) found = 1;
        end
        check("mask_beginCalc_seen", found, 1);
        bus.gateReady = 4'b1111;
        tick();
        check("mask_beginElem_c1", int'(bus.beginElem), 0);
        bus.gateReady = 4'b0001;
        bus.elemDone  = 1'b1;
        tick();
        check("mask_beginElem_c2", int'(bus.beginElem), 0);
        bus.gateReady = 4'b0100;
        bus.elemDone  = 1'b0;
        tick();
        check("mask_beginElem_c3", int'(bus.beginElem), 0);
        bus.gateReady = 4'b1010;
        tick();
        check("mask_beginElem_c4", int'(bus.beginElem), 1);
        bus.gateReady = 4'b0000;
        tick();
        check("mask_wait_elem_busy", int'(bus.busy), 1);
        bus.gateReady = 4'b1111;
        tick();
        check("mask_no_early_hw", int'(bus.hiddenWrite), 0);
        bus.gateReady = 4'b0000;
        bus.elemDone  = 1'b1;
        tick();
        bus.elemDone  = 1'b0;
        check("mask_hiddenWrite", int'(bus.hiddenWrite), 1);
        check("mask_stepIndex", int'(bus.stepIndex), 0);
        tick();
        check("mask_seqDone", int'(bus.seqDone), 1);
        tick();
        check("mask_idle", int'(bus.busy), 0);

        // Abort during WAIT_ELEM of step 1 of 4.
        auto_resp = 1'b1;
        gate_dly  = 1;
        elem_dly  = 3;
        gate_cnt  = 0;
        elem_cnt  = 0;
        found     = 0;
        bus.startSeq = 1'b1;
        bus.numSteps = STEP_BW'(4);
        for (int k = 0; (k < 40) && (found == 0); k++) begin
            tick();
            bus.startSeq = 1'b0;
            if (bus.beginElem && (bus.stepIndex == STEP_BW'(1))) found = 1;
        end
        check("abort_step1_reached", found, 1);
        tick();
        check("abort_in_wait_elem", int'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_hiddenWrite", int'(bus.hiddenWrite), 0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            extra += int'(bus.hiddenWrite) + int'(bus.seqDone) + int'(bus.busy);
        end
        check("abort_quiet_after", extra, 0);
        run_seq(vecs[2]);

        // Asynchronous reset between edges during WAIT_GATES of step 1.
        gate_dly = 5;
        elem_dly = 1;
        gate_cnt = 0;
        elem_cnt = 0;
        found    = 0;
        bus.startSeq = 1'b1;
        bus.numSteps = STEP_BW'(2);
        for (int k = 0; (k < 40) && (found == 0); k++) begin
            tick();
            bus.startSeq = 1'b0;
            if (bus.beginCalc && (bus.stepIndex == STEP_BW'(1))) found = 1;
        end
        check("rst_step1_reached", found, 1);
        tick();
        check("rst_busy_before", int'(bus.busy), 1);
        #2;
        reset = 1'b1;
        bus.startSeq = 1'b1;
        #1;
        check("rst_async_busy", int'(bus.busy), 0);
        check("rst_async_stepIndex", int'(bus.stepIndex), 0);
        @(posedge clock);
        #1;
        check("rst_held_busy", int'(bus.busy), 0);
        @(negedge clock);
        reset         = 1'b0;
        bus.startSeq  = 1'b0;
        auto_resp     = 1'b0;
        gate_cnt      = 0;
        elem_cnt      = 0;
        bus.gateReady = {NUM_GATES{1'b0}};
        bus.elemDone  = 1'b0;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            extra += int'(bus.busy) + int'(bus.inputRead) + int'(bus.beginCalc) +
                     int'(bus.beginElem) + int'(bus.hiddenWrite) + int'(bus.seqDone);
        end
        check("rst_release_quiet", extra, 0);
        run_seq(vecs[6]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
